// File: rtl/axi4l_pkg.sv
// Shared AXI4-lite response codes and the response-entry layout used by the banked read path.
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Widest data bus an entry can carry; narrower buses zero-extend into it.
  localparam int RESP_DATA_MAX = 64;

  typedef struct packed {
    logic [1:0]               resp;
    logic [RESP_DATA_MAX-1:0] data;
  } resp_entry_t;

  function automatic logic [1:0] resp_code(input logic oor, input logic [1:0] coll);
    if (oor) return RESP_DECERR;
    if (|coll) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; head entry is visible on rdata whenever not empty.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 34
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/axi4l_read_banked.sv
// AXI4-lite read slave in front of NB_BANK interleaved RAM banks with fixed read latency.
module axi4l_read_banked
  import axi4l_pkg::*;
#(
  parameter int MAX_OR     = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NB_BANK    = 4,
  parameter int RD_LATENCY = 1,
  parameter int MEM_WORDS  = 2**ADDR_WIDTH
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic                                  arvalid,
  output logic                                  arready,
  input  logic [ADDR_WIDTH-1:0]                 araddr,
  input  logic [2:0]                            arprot,
  output logic                                  rvalid,
  input  logic                                  rready,
  output logic [DATA_WIDTH-1:0]                 rdata,
  output logic [1:0]                            rresp,
  output logic [NB_BANK-1:0]                    rden,
  output logic [ADDR_WIDTH-$clog2(NB_BANK)-1:0] rdaddr,
  input  logic [NB_BANK*DATA_WIDTH-1:0]         rddata,
  input  logic [NB_BANK*2-1:0]                  rdcollision
);

  localparam int BANK_W = $clog2(NB_BANK);
  localparam int WORD_W = ADDR_WIDTH - BANK_W;
  localparam int CNT_W  = $clog2(MAX_OR) + 1;

  logic [CNT_W-1:0]      outstanding;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  oor_ar;
  logic [BANK_W-1:0]     bank_ar;
  logic [WORD_W-1:0]     word_ar;

  logic                  vld_p0;
  logic [BANK_W-1:0]     bank_p0;
  logic                  oor_p0;
  logic                  vld_p1  [RD_LATENCY];
  logic [BANK_W-1:0]     bank_p1 [RD_LATENCY];
  logic                  oor_p1  [RD_LATENCY];

  logic [DATA_WIDTH-1:0] bank_data [NB_BANK];
  logic [1:0]            bank_coll [NB_BANK];
  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  resp_entry_t           push_entry;
  resp_entry_t           head_entry;
  logic                  unused_bits;

  assign bank_ar = araddr[BANK_W-1:0];
  assign word_ar = araddr[ADDR_WIDTH-1:BANK_W];
  assign oor_ar  = ({1'b0, araddr} >= (ADDR_WIDTH+1)'(MEM_WORDS));

  assign arready = !areset && (outstanding != CNT_W'(MAX_OR));
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;

  // Counter covers pipe plus FIFO, so the FIFO can never be pushed while full.
  always_ff @(posedge aclk) begin
    if (areset) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stage p0: bank strobe and word address issued the cycle after acceptance.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rden    <= '0;
      rdaddr  <= '0;
      vld_p0  <= 1'b0;
      bank_p0 <= '0;
      oor_p0  <= 1'b0;
    end else begin
      rden    <= (ar_hs && !oor_ar) ? (NB_BANK'(1) << bank_ar) : '0;
      if (ar_hs && !oor_ar) rdaddr <= word_ar;
      vld_p0  <= ar_hs;
      bank_p0 <= bank_ar;
      oor_p0  <= oor_ar;
    end
  end

  // Stage p1: delay line matching the bank read latency.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_p1[i]  <= 1'b0;
        bank_p1[i] <= '0;
        oor_p1[i]  <= 1'b0;
      end
    end else begin
      vld_p1[0]  <= vld_p0;
      bank_p1[0] <= bank_p0;
      oor_p1[0]  <= oor_p0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p1[i]  <= vld_p1[i-1];
        bank_p1[i] <= bank_p1[i-1];
        oor_p1[i]  <= oor_p1[i-1];
      end
    end
  end

  for (genvar b = 0; b < NB_BANK; b++) begin : g_bank
    assign bank_data[b] = rddata[b*DATA_WIDTH +: DATA_WIDTH];
    assign bank_coll[b] = rdcollision[2*b +: 2];
  end

  assign fifo_push = vld_p1[RD_LATENCY-1];

  always_comb begin
    push_entry      = '0;
    push_entry.resp = resp_code(oor_p1[RD_LATENCY-1], bank_coll[bank_p1[RD_LATENCY-1]]);
    if (!oor_p1[RD_LATENCY-1])
      push_entry.data = RESP_DATA_MAX'(bank_data[bank_p1[RD_LATENCY-1]]);
  end

  sync_fifo #(
    .DEPTH (MAX_OR),
    .WIDTH ($bits(resp_entry_t))
  ) u_resp_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (fifo_push),
    .wdata  (push_entry),
    .pop    (r_hs),
    .rdata  (head_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Masking with empty keeps R outputs at zero during and after reset.
  assign rvalid = !fifo_empty;
  assign rdata  = fifo_empty ? '0 : head_entry.data[DATA_WIDTH-1:0];
  assign rresp  = fifo_empty ? '0 : head_entry.resp;

  assign unused_bits = ^{arprot, head_entry.data};

  a_fifo_no_overflow: assert property (@(posedge aclk) disable iff (areset)
    !(fifo_push && fifo_full));

  a_counter_bound: assert property (@(posedge aclk) disable iff (areset)
    outstanding <= CNT_W'(MAX_OR));

endmodule

// File: doc/axi4l_read_banked.md
AXI4L_READ_BANKED -- requirements
Module: axi4l_read_banked

Interface
REQ-001 The block SHALL have parameter MAX_OR, default 8, meaning max outstanding reads (power of 2, >=2).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning AXI address width in bits.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning data width in bits.
REQ-004 The block SHALL have parameter NB_BANK, default 4, meaning number of RAM banks (power of 2, >=2).
REQ-005 The block SHALL have parameter RD_LATENCY, default 1, meaning bank read latency in cycles (1..4).
REQ-006 The block SHALL have parameter MEM_WORDS, default 2**ADDR_WIDTH, meaning number of valid addresses; addresses >= MEM_WORDS are out of range.
REQ-007 The block SHALL have port aclk, input, 1, the single clock for all logic.
REQ-008 The block SHALL have port areset, input, 1, the reset; one clock, reset synchronous and active-high.
REQ-009 The block SHALL have ports arvalid in 1, arready out 1, araddr in ADDR_WIDTH and arprot in 3, forming the AXI4-lite AR channel; arprot is ignored.
REQ-010 The block SHALL have ports rvalid out 1, rready in 1, rdata out DATA_WIDTH and rresp out 2, forming the AXI4-lite R channel.
REQ-011 The block SHALL have port rden, output, NB_BANK, one-hot per-bank read enable.
REQ-012 The block SHALL have port rdaddr, output, ADDR_WIDTH-log2(NB_BANK), the word address within a bank, shared by all banks.
REQ-013 The block SHALL have port rddata, input, NB_BANK*DATA_WIDTH, with bank b on bits [b*DATA_WIDTH +: DATA_WIDTH].
REQ-014 The block SHALL have port rdcollision, input, NB_BANK*2, with bank b on bits [2b +: 2], nonzero meaning collision.

Function
REQ-015 The block SHALL decode bank = araddr[log2(NB_BANK)-1:0] and word = the remaining upper araddr bits.
REQ-016 The block SHALL count outstanding reads: +1 on AR handshake, -1 on R handshake, unchanged when both occur in the same cycle.
REQ-017 The block SHALL drive arready = (outstanding != MAX_OR), combinational from the counter, and low while areset is high.
REQ-018 For an in-range AR handshake in cycle T, the block SHALL assert rden[bank] with rdaddr=word, registered, for exactly cycle T+1.
REQ-019 For an out-of-range AR handshake, the block SHALL assert no rden and SHALL return rdata=0, rresp=2'b11 (DECERR), with the same latency as an in-range read.
REQ-020 The block SHALL carry valid, bank index and out-of-range flag through a RD_LATENCY-deep shift pipe and sample bank rddata/rdcollision in cycle T+1+RD_LATENCY.
REQ-021 The block SHALL write the sampled {rresp, rdata} into a MAX_OR-deep response FIFO at the end of cycle T+1+RD_LATENCY.
REQ-022 The block SHALL set rresp=2'b10 (SLVERR) when the sampled rdcollision is nonzero, else 2'b00.
REQ-023 rvalid SHALL equal FIFO not-empty, so first rvalid comes in cycle T+2+RD_LATENCY; rdata/rresp SHALL be FIFO head; FIFO SHALL pop on rvalid&rready.
REQ-024 rvalid, rdata and rresp SHALL be held stable while rvalid=1 and rready=0.
REQ-025 The block SHALL sustain one AR and one R handshake per cycle; responses SHALL be returned in acceptance order.
REQ-026 The counter SHALL guarantee the FIFO plus pipe never hold more than MAX_OR entries; a FIFO write while full is impossible and SHALL be asserted against.
REQ-027 The counter SHALL be at least log2(MAX_OR)+1 bits, with no wrap.

Reset
REQ-028 While areset is high, the block SHALL clear the counter, pipe, rden (0), rdaddr (0), FIFO pointers, rvalid (0), rdata (0) and rresp (0).
REQ-029 A reset asserted mid-operation SHALL discard all in-flight and queued reads; no response SHALL be issued for them after areset deasserts.
REQ-030 arready SHALL be high in the first cycle after areset deasserts.

Structure
REQ-031 RESP_OKAY/RESP_SLVERR/RESP_DECERR constants and the response-entry typedef SHALL reside in shared package axi4l_pkg.
REQ-032 The response FIFO SHALL be sub-module sync_fifo (parameters DEPTH, WIDTH; ports aclk, areset, push, pop, full, empty) using first-word fall-through.

Verification
REQ-033 Single read, NB_BANK=4, RD_LATENCY=1: araddr=0x06 in cycle 0 -> rden=4'b0100, rdaddr=1 in cycle 1; rvalid in cycle 3, rresp=00.
REQ-034 Back-pressure: 8 reads with rready=0 -> arready low after the 8th; 9th held; one R pop -> arready high next cycle, 9th accepted.
REQ-035 Collision: rdcollision for bank 2 = 2'b01 in the sample cycle -> rresp=2'b10, data still returned.
REQ-036 Out of range: MEM_WORDS=200, araddr=0xF0 -> rden stays 0; rdata=0, rresp=2'b11 at cycle 3.
REQ-037 Streaming: 32 back-to-back reads with rready=1, RD_LATENCY=3 -> one rvalid per cycle, ordered data, counter never exceeds MAX_OR.
REQ-038 Reset mid-stream: areset for 1 cycle with 5 reads in flight -> rvalid=0 afterwards, no stale responses, arready=1.
